// File: rtl/serial_rx_ctrl.sv
// serial_rx_ctrl
//   Receive-side sequencer for an asynchronous serial link. It drives an
//   external serial-to-parallel shift register that is DATA_BITS+1 wide.
//   It detects a start bit and re-samples it at mid-bit to reject glitches.
//   It then strobes the shift register at the centre of every data bit and
//   of the stop bit. Finally it commits the frame or flags a framing error.
//
// Ports
//   clk           : rising-edge clock
//   rst           : synchronous active-high reset
//   serial_in     : serial line, already synchronized to clk, idles high
//   shift_strobe  : 1-cycle pulse, shift_enable of the shift register
//   load_buffer   : 1-cycle pulse, commit shift register to output buffer
//   framing_error : sticky, set on a bad stop bit, cleared by the next
//                   validated start bit or by rst
//   rx_busy       : high whenever the controller is not idle
//
// All outputs are registered. Their next values are derived from the
// next-state logic, so each pulse lands in the same cycle that the
// corresponding state/timer condition holds.
module serial_rx_ctrl #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic serial_in,
  output logic shift_strobe,
  output logic load_buffer,
  output logic framing_error,
  output logic rx_busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int TW   = $clog2(CLKS_PER_BIT);
  localparam int CW   = $clog2(DATA_BITS + 2);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_RECV  = 2'd2;
  localparam logic [1:0] ST_CHECK = 2'd3;

  // The timer is zero-based. A count of N cycles therefore ends at value
  // N-1. This keeps it within $clog2(CLKS_PER_BIT) bits even when
  // CLKS_PER_BIT is a power of two.
  localparam logic [TW-1:0] TMR_ZERO = TW'(0);
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);
  localparam logic [TW-1:0] TMR_MID  = TW'(HALF - 1);
  localparam logic [TW-1:0] TMR_BIT  = TW'(CLKS_PER_BIT - 1);

  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  // Bit count before the final (stop-bit) strobe.
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_BITS);

  logic [1:0]    state_r;
  logic [1:0]    state_s;
  logic [TW-1:0] timer_r;
  logic [TW-1:0] timer_s;
  logic [CW-1:0] bit_cnt_r;
  logic [CW-1:0] bit_cnt_s;
  logic          prev_in_r;
  logic          stop_bit_r;
  logic          stop_bit_s;
  logic          framing_error_r;
  logic          framing_error_s;
  logic          shift_strobe_r;
  logic          shift_strobe_s;
  logic          load_buffer_r;
  logic          load_buffer_s;
  logic          rx_busy_r;
  logic          rx_busy_s;
  logic          start_det_s;

  assign start_det_s = prev_in_r & ~serial_in;

  // Next-state, timer, bit counter, stop-bit capture and error flag.
  always_comb begin
    state_s         = state_r;
    timer_s         = timer_r;
    bit_cnt_s       = bit_cnt_r;
    stop_bit_s      = stop_bit_r;
    framing_error_s = framing_error_r;
    case (state_r)
      ST_IDLE: begin
        timer_s   = TMR_ZERO;
        bit_cnt_s = CNT_ZERO;
        if (start_det_s) begin
          state_s = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (timer_r == TMR_MID) begin
          timer_s = TMR_ZERO;
          if (!serial_in) begin
            // A start bit that is still low at mid-bit is genuine. It opens a
            // new frame, so any earlier error is cleared now.
            state_s         = ST_RECV;
            framing_error_s = 1'b0;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          timer_s = timer_r + TMR_ONE;
        end
      end
      ST_RECV: begin
        if (timer_r == TMR_BIT) begin
          timer_s    = TMR_ZERO;
          bit_cnt_s  = bit_cnt_r + CNT_ONE;
          // Every strobe overwrites this capture, so after the last strobe
          // it holds the stop bit.
          stop_bit_s = serial_in;
          if (bit_cnt_r == CNT_LAST) begin
            state_s = ST_CHECK;
          end else begin
            state_s = ST_RECV;
          end
        end else begin
          timer_s = timer_r + TMR_ONE;
        end
      end
      ST_CHECK: begin
        state_s   = ST_IDLE;
        timer_s   = TMR_ZERO;
        bit_cnt_s = CNT_ZERO;
        if (!stop_bit_r) begin
          framing_error_s = 1'b1;
        end else begin
          framing_error_s = framing_error_r;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        timer_s   = TMR_ZERO;
        bit_cnt_s = CNT_ZERO;
      end
    endcase
  end

  // Output look-ahead. Each pulse is registered for the cycle in which the
  // next state/timer satisfies its condition.
  always_comb begin
    shift_strobe_s = (state_s == ST_RECV) && (timer_s == TMR_BIT);
    load_buffer_s  = (state_s == ST_CHECK) && stop_bit_s;
    rx_busy_s      = (state_s != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      timer_r         <= TMR_ZERO;
      bit_cnt_r       <= CNT_ZERO;
      prev_in_r       <= 1'b1;
      stop_bit_r      <= 1'b1;
      framing_error_r <= 1'b0;
      shift_strobe_r  <= 1'b0;
      load_buffer_r   <= 1'b0;
      rx_busy_r       <= 1'b0;
    end else begin
      state_r         <= state_s;
      timer_r         <= timer_s;
      bit_cnt_r       <= bit_cnt_s;
      prev_in_r       <= serial_in;
      stop_bit_r      <= stop_bit_s;
      framing_error_r <= framing_error_s;
      shift_strobe_r  <= shift_strobe_s;
      load_buffer_r   <= load_buffer_s;
      rx_busy_r       <= rx_busy_s;
    end
  end

  assign shift_strobe  = shift_strobe_r;
  assign load_buffer   = load_buffer_r;
  assign framing_error = framing_error_r;
  assign rx_busy       = rx_busy_r;

endmodule

// File: doc/serial_rx_ctrl.md
# serial_rx_ctrl

Receive-side controller that sequences an external serial-to-parallel shift register (`flex_stp_sr`, `NUM_BITS = DATA_BITS+1`) for an asynchronous serial link. It detects the start bit and validates it at mid-bit. It times each bit period and pulses `shift_strobe` at the centre of every data bit and the stop bit. It then checks the stop bit and either pulses `load_buffer` to commit the frame or flags a framing error. It sits between the synchronized serial input pin and the receive datapath (shift register plus output buffer).

## Interface
- `DATA_BITS`, default 8: data bits per frame, ≥1.
- `CLKS_PER_BIT`, default 10: clock cycles per serial bit, ≥4. `HALF = CLKS_PER_BIT/2` (floor).

- `clk`, in, 1: rising-edge clock.
- `rst`, in, 1: synchronous, active-high reset.
- `serial_in`, in, 1: serial line, already synchronized to `clk`; idles high.
- `shift_strobe`, out, 1: one-cycle pulse; drives `shift_enable` of the shift register.
- `load_buffer`, out, 1: one-cycle pulse; commits the shift register contents to the output buffer.
- `framing_error`, out, 1: sticky; set on a bad stop bit.
- `rx_busy`, out, 1: high whenever state ≠ IDLE.

## Operation
- Internal `prev_in` register holds `serial_in` from the previous cycle. Start detect = `prev_in==1 && serial_in==0`.
- Timer width is `$clog2(CLKS_PER_BIT)`. Bit counter width is `$clog2(DATA_BITS+2)`.
- States:
  - **IDLE**: timer=0, bit count=0. On start detect → START.
  - **START**: timer counts 1..HALF.
    - At timer==HALF, if `serial_in==0` → RECV: timer cleared, `framing_error` cleared.
    - At timer==HALF, if `serial_in==1` → IDLE (glitch rejected, no other effect).
  - **RECV**: timer counts 1..CLKS_PER_BIT.
    - At timer==CLKS_PER_BIT: `shift_strobe`=1 that cycle, timer cleared, bit count +1, and `serial_in` is captured into `stop_bit`.
    - When the strobe raises bit count to DATA_BITS+1 → CHECK.
  - **CHECK** (one cycle):
    - If `stop_bit==1`: `load_buffer`=1, then → IDLE.
    - Else: `framing_error`←1, no load, then → IDLE.
- The data stays in the shift register whatever the stop-bit result. Only `load_buffer` commits it.
- `framing_error` holds from being set until the next validated start bit or `rst`.
- `shift_strobe` and `load_buffer` are never high in the same cycle.

## Timing
- Reset (`rst` high at a rising edge) forces, from the next cycle:
  - state=IDLE, timer=0, bit count=0, `prev_in`=1, `stop_bit`=1.
  - `shift_strobe`=0, `load_buffer`=0, `framing_error`=0, `rx_busy`=0.
- Reset has priority over every transition, including mid-frame. A frame interrupted by reset produces no further strobe or load.
- Let t0 be the cycle in which start detect is true in IDLE.
  - `rx_busy` rises at t0+1.
  - Mid-start sample happens at t0+HALF.
  - Strobe k (k=1..DATA_BITS+1) occurs at t0+HALF+k·CLKS_PER_BIT. The last strobe samples the stop bit.
  - CHECK (`load_buffer` or error set) occurs at t0+HALF+(DATA_BITS+1)·CLKS_PER_BIT+1.
  - IDLE is reached, with `rx_busy`=0, the following cycle.
- A falling edge during CHECK is not detected. In IDLE, a falling edge is detected the first cycle `serial_in` is low while `prev_in` is high. `prev_in` updates in every state, so a line that is already low on entering IDLE waits for a fresh high→low edge.
- All outputs are registered or decoded from state and timer only. No combinational path runs from `serial_in` to any output.

## Test plan
- Reset and idle: hold `rst` 2 cycles with `serial_in`=1, then idle 50 cycles → all outputs 0, no strobes.
- Good frame (defaults): send 0, 0xA5 LSB-first, 1, each bit 10 cycles, first low at t0 → 9 strobes at t0+15, 25, …, 95; `load_buffer` at t0+96 only; `framing_error`=0; `rx_busy` high t0+1..t0+96.
- Glitch: `serial_in` low 3 cycles then high → no strobe, `rx_busy` back to 0 by t0+6, `framing_error` unchanged.
- Bad stop: same frame with stop bit 0, then line high → 9 strobes, no `load_buffer`, `framing_error`=1 from t0+97. It stays 1 until the next frame's mid-start sample validates, then clears.
- Reset mid-frame: assert `rst` for 1 cycle at t0+40 → no strobes after t0+40, no `load_buffer`, all outputs 0. A subsequent good frame is received normally.
- Back-to-back: second start bit begins immediately after the first frame's stop bit (10 cycles later) → two `load_buffer` pulses, each exactly 81 cycles after its own t0+15.
